// File: rtl/nlp_fw_read_arbiter.sv
// Two-requester Fw RAM read arbiter: alternating grants, tagged read-return pipeline.
// Define NLP_FW_ARB_LOCK_EN to let lock0/lock1 hold ownership for bursts.
module nlp_fw_read_arbiter #(
    parameter int unsigned N1     = 80,
    parameter int unsigned AW     = 10,
    parameter int unsigned RD_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic          lock0,
    input  logic          lock1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          rvalid0,
    output logic          rvalid1,
    output logic [N1-1:0] rdata,
    output logic [AW-1:0] ram_addr,
    input  logic [N1-1:0] ram_q
);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e        state_q, state_d;
    logic          gnt0_q, gnt0_d;
    logic          gnt1_q, gnt1_d;
    logic          rvalid0_q, rvalid1_q;
    logic [N1-1:0] rdata_q;
    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [1:0]    tag_q [RD_LAT];
    logic [1:0]    tag_out;
    logic          elig0, elig1;

`ifndef NLP_FW_ARB_LOCK_EN
    logic unused_lock;
    assign unused_lock = lock0 ^ lock1;
`endif

    always_comb begin
        // A requester whose grant is showing this cycle is still holding req; skip it.
        elig0 = req0 & ~gnt0_q;
        elig1 = req1 & ~gnt1_q;
`ifdef NLP_FW_ARB_LOCK_EN
        if (state_q == StOwn0 && lock0) elig1 = 1'b0;
        if (state_q == StOwn1 && lock1) elig0 = 1'b0;
`endif
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        case (state_q)
            StOwn0: begin
                if (elig1)      gnt1_d = 1'b1;
                else if (elig0) gnt0_d = 1'b1;
            end
            StOwn1: begin
                if (elig0)      gnt0_d = 1'b1;
                else if (elig1) gnt1_d = 1'b1;
            end
            default: begin
                if (elig0)      gnt0_d = 1'b1;
                else if (elig1) gnt1_d = 1'b1;
            end
        endcase

        if (gnt0_d)      state_d = StOwn0;
        else if (gnt1_d) state_d = StOwn1;
        else             state_d = StIdle;
`ifdef NLP_FW_ARB_LOCK_EN
        // Keep ownership while the lock holder is between burst beats.
        if (!gnt0_d && !gnt1_d &&
            ((state_q == StOwn0 && lock0) || (state_q == StOwn1 && lock1))) begin
            state_d = state_q;
        end
`endif

        ram_addr_d = ram_addr_q;
        if (gnt0_d)      ram_addr_d = addr0;
        else if (gnt1_d) ram_addr_d = addr1;
    end

    assign tag_out = tag_q[RD_LAT-1];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            gnt0_q     <= 1'b0;
            gnt1_q     <= 1'b0;
            ram_addr_q <= '0;
            rvalid0_q  <= 1'b0;
            rvalid1_q  <= 1'b0;
            rdata_q    <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) tag_q[i] <= 2'b00;
        end else begin
            state_q    <= state_d;
            gnt0_q     <= gnt0_d;
            gnt1_q     <= gnt1_d;
            ram_addr_q <= ram_addr_d;
            // Grant register is the tag for the cycle ram_addr is presented.
            tag_q[0]   <= {gnt1_q, gnt0_q};
            for (int i = 1; i < int'(RD_LAT); i++) tag_q[i] <= tag_q[i-1];
            rvalid0_q  <= tag_out[0];
            rvalid1_q  <= tag_out[1];
            if (|tag_out) rdata_q <= ram_q;
        end
    end

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign rvalid0  = rvalid0_q;
    assign rvalid1  = rvalid1_q;
    assign rdata    = rdata_q;
    assign ram_addr = ram_addr_q;

endmodule
